// File: rtl/dsi_axis_test_pattern_pkg.sv
// Shared types and constants for the DSI AXI4-Stream test pattern generator.
package dsi_axis_test_pattern_pkg;

    localparam int unsigned RGB_BITS       = 24;
    localparam int unsigned TDATA_BITS     = 32;
    localparam int unsigned FRAME_CNT_BITS = 16;
    localparam int unsigned BAR_IDX_BITS   = 3;

    typedef enum logic [1:0] {
        TPG_SOLID   = 2'd0,
        TPG_BARS    = 2'd1,
        TPG_RAMP    = 2'd2,
        TPG_CHECKER = 2'd3
    } tpg_pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } tpg_state_e;

    // Output register payload; eof marks the final beat of a frame.
    typedef struct packed {
        logic                  eof;
        logic                  tuser;
        logic                  tlast;
        logic [TDATA_BITS-1:0] tdata;
    } axis_beat_t;

    function automatic logic [RGB_BITS-1:0] bar_color(input logic [BAR_IDX_BITS-1:0] idx);
        logic [RGB_BITS-1:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dsi_axis_test_pattern_pixel.sv
// Combinational pixel colour for the current raster position and latched pattern settings.
module dsi_axis_test_pattern_pixel
    import dsi_axis_test_pattern_pkg::*;
#(
    parameter int unsigned g_dim_bits     = 12,
    parameter int unsigned g_checker_log2 = 4
) (
    input  logic [g_dim_bits-1:0]     x,
    input  logic [g_dim_bits-1:0]     y,
    input  logic [BAR_IDX_BITS-1:0]   bar_idx,
    input  logic [FRAME_CNT_BITS-1:0] frame_cnt,
    input  tpg_pattern_e              pattern,
    input  logic [RGB_BITS-1:0]       color,
    output logic [RGB_BITS-1:0]       rgb_c
);

    localparam logic [FRAME_CNT_BITS-1:0] CHK_MASK = FRAME_CNT_BITS'(1) << g_checker_log2;

    logic [FRAME_CNT_BITS-1:0] chk_x;
    logic [FRAME_CNT_BITS-1:0] chk_y;
    logic                      chk_sel;

    // Checker scrolls horizontally by one pixel per completed frame.
    always_comb begin
        chk_x   = FRAME_CNT_BITS'(x) + frame_cnt;
        chk_y   = FRAME_CNT_BITS'(y);
        chk_sel = |((chk_x ^ chk_y) & CHK_MASK);
        rgb_c   = color;
        unique case (pattern)
            TPG_SOLID:   rgb_c = color;
            TPG_BARS:    rgb_c = bar_color(bar_idx);
            TPG_RAMP:    rgb_c = {3{x[7:0]}};
            TPG_CHECKER: rgb_c = chk_sel ? 24'hFFFFFF : 24'h000000;
        endcase
    end

endmodule

// File: rtl/dsi_axis_test_pattern.sv
// AXI4-Stream RGB888 test pattern source: frame FSM, raster counters and output register stage.
module dsi_axis_test_pattern
    import dsi_axis_test_pattern_pkg::*;
#(
    parameter int unsigned g_pixels_per_clock = 1,
    parameter int unsigned g_dim_bits         = 12,
    parameter int unsigned g_checker_log2     = 4
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_n_a_i,
    input  logic                      enable_i,
    input  logic [1:0]                pattern_i,
    input  logic [RGB_BITS-1:0]       color_i,
    input  logic [g_dim_bits-1:0]     width_i,
    input  logic [g_dim_bits-1:0]     height_i,
    output logic [TDATA_BITS-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic [FRAME_CNT_BITS-1:0] frame_cnt_o
);

    localparam int unsigned BAR_SHIFT = 3;
    localparam logic [BAR_IDX_BITS-1:0] BAR_IDX_MAX = '1;

    if (g_pixels_per_clock != 1) begin : g_ppc_check
        $error("dsi_axis_test_pattern: only g_pixels_per_clock = 1 is supported");
    end

    tpg_state_e                state;
    tpg_state_e                state_nxt;
    tpg_pattern_e              pattern_s;
    logic [RGB_BITS-1:0]       color_s;
    logic [g_dim_bits-1:0]     width_s;
    logic [g_dim_bits-1:0]     height_s;
    logic [g_dim_bits-1:0]     bar_w_s;
    logic [g_dim_bits-1:0]     x;
    logic [g_dim_bits-1:0]     y;
    logic [g_dim_bits-1:0]     bar_cnt;
    logic [BAR_IDX_BITS-1:0]   bar_idx;
    logic                      gen_done;
    logic                      valid_q;
    axis_beat_t                beat_q;
    logic [RGB_BITS-1:0]       rgb_c;
    logic [g_dim_bits-1:0]     bar_w_c;
    logic                      x_last_c;
    logic                      y_last_c;
    logic                      load_en_c;
    logic                      accept_last_c;

    assign bar_w_c       = ((width_i >> BAR_SHIFT) == '0) ? g_dim_bits'(1) : (width_i >> BAR_SHIFT);
    assign x_last_c      = (x == width_s - g_dim_bits'(1));
    assign y_last_c      = (y == height_s - g_dim_bits'(1));
    assign load_en_c     = !valid_q || m_axis_tready;
    assign accept_last_c = valid_q && m_axis_tready && beat_q.eof;

    always_ff @(posedge clk_sys_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frames always run to completion; enable_i is only consulted at frame boundaries.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (enable_i) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = (width_i == '0 || height_i == '0) ? ST_IDLE : ST_STREAM;
            ST_STREAM: if (accept_last_c) state_nxt = enable_i ? ST_LOAD : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    dsi_axis_test_pattern_pixel #(
        .g_dim_bits     (g_dim_bits),
        .g_checker_log2 (g_checker_log2)
    ) u_pixel (
        .x         (x),
        .y         (y),
        .bar_idx   (bar_idx),
        .frame_cnt (frame_cnt_o),
        .pattern   (pattern_s),
        .color     (color_s),
        .rgb_c     (rgb_c)
    );

    // x/y address the next pixel to be placed in the output register.
    always_ff @(posedge clk_sys_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            pattern_s   <= TPG_SOLID;
            color_s     <= '0;
            width_s     <= '0;
            height_s    <= '0;
            bar_w_s     <= '0;
            x           <= '0;
            y           <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            gen_done    <= 1'b0;
            valid_q     <= 1'b0;
            beat_q      <= '0;
            busy_o      <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            busy_o <= (state_nxt != ST_IDLE);
            if (accept_last_c) begin
                frame_cnt_o <= frame_cnt_o + FRAME_CNT_BITS'(1);
            end
            if (state == ST_LOAD) begin
                pattern_s <= tpg_pattern_e'(pattern_i);
                color_s   <= color_i;
                width_s   <= width_i;
                height_s  <= height_i;
                bar_w_s   <= bar_w_c;
                x         <= '0;
                y         <= '0;
                bar_cnt   <= '0;
                bar_idx   <= '0;
                gen_done  <= 1'b0;
            end else if (state == ST_STREAM && load_en_c) begin
                if (gen_done) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q      <= 1'b1;
                    beat_q.tdata <= {8'h00, rgb_c};
                    beat_q.tlast <= x_last_c;
                    beat_q.tuser <= (x == '0) && (y == '0);
                    beat_q.eof   <= x_last_c && y_last_c;
                    if (x_last_c) begin
                        x       <= '0;
                        bar_cnt <= '0;
                        bar_idx <= '0;
                        if (y_last_c) begin
                            gen_done <= 1'b1;
                        end else begin
                            y <= y + g_dim_bits'(1);
                        end
                    end else begin
                        x <= x + g_dim_bits'(1);
                        if (bar_cnt == bar_w_s - g_dim_bits'(1)) begin
                            bar_cnt <= '0;
                            if (bar_idx != BAR_IDX_MAX) begin
                                bar_idx <= bar_idx + BAR_IDX_BITS'(1);
                            end
                        end else begin
                            bar_cnt <= bar_cnt + g_dim_bits'(1);
                        end
                    end
                end
            end
        end
    end

    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = beat_q.tdata;
    assign m_axis_tlast  = beat_q.tlast;
    assign m_axis_tuser  = beat_q.tuser;
    assign frame_done_o  = accept_last_c;

endmodule
